demux_buffered: RTL and testbench

- One-to-two routing block: takes one 32-bit valid/ready stream plus a select bit, and steers each word to one of two output streams.
- Each output is buffered in its own FIFO, so a stalled consumer blocks only its own path.
- Inverse of the datapath 2:1 select. Used where one producer (e.g. memory response port) feeds two consumers (fetch side = 0, load side = 1).

---
 rtl/demux_buffered.sv | 103 ++++++++++
 tb/tb_demux_buffered.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_buffered.sv
// demux_buffered: steers one valid/ready stream into one of two output
// streams, each decoupled by its own FIFO so a stalled consumer only blocks
// words destined for itself.
module demux_buffered #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_sel,
  output logic                     out0_valid,
  input  logic                     out0_ready,
  output logic [WIDTH-1:0]         out0_data,
  output logic [$clog2(DEPTH):0]   out0_count,
  output logic                     out1_valid,
  input  logic                     out1_ready,
  output logic [WIDTH-1:0]         out1_data,
  output logic [$clog2(DEPTH):0]   out1_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Per-FIFO state, index 0 = fetch side, index 1 = load side.
  logic [CW-1:0]    count_q  [2];
  logic [CW-1:0]    count_d  [2];
  logic [PW-1:0]    wr_ptr_q [2];
  logic [PW-1:0]    wr_ptr_d [2];
  logic [PW-1:0]    rd_ptr_q [2];
  logic [PW-1:0]    rd_ptr_d [2];
  logic [WIDTH-1:0] mem_q    [2][DEPTH];

  logic [1:0] valid;
  logic [1:0] push;
  logic [1:0] pop;

  assign valid[0] = (count_q[0] != '0);
  assign valid[1] = (count_q[1] != '0);

  // Acceptance depends only on the selected FIFO's registered fill level, so a
  // pop in the same cycle never frees a slot for the incoming word.
  assign in_ready = rst_n && (count_q[in_sel] != FULL_CNT);

  assign push[0] = in_valid && in_ready && !in_sel;
  assign push[1] = in_valid && in_ready &&  in_sel;
  assign pop     = valid & {out1_ready, out0_ready};

  // Next pointer/count values; pointers wrap naturally because DEPTH is 2^PW.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      count_d[i]  = count_q[i];
      if (push[i]) wr_ptr_d[i] = wr_ptr_q[i] + PW'(1);
      if (pop[i])  rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
      case ({push[i], pop[i]})
        2'b10:   count_d[i] = count_q[i] + CW'(1);
        2'b01:   count_d[i] = count_q[i] - CW'(1);
        default: count_d[i] = count_q[i];
      endcase
    end
  end

  // Control state register; reset clears occupancy immediately.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        count_q[i]  <= '0;
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        count_q[i]  <= count_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
      end
    end
  end

  // Word storage for both FIFOs.
  // NOTE: storage is deliberately not reset; zero occupancy already hides stale
  // entries, and leaving it out lets the array map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_data;
    end
  end

  assign out0_valid = valid[0];
  assign out1_valid = valid[1];
  assign out0_count = count_q[0];
  assign out1_count = count_q[1];
  assign out0_data  = valid[0] ? mem_q[0][rd_ptr_q[0]] : '0;
  assign out1_data  = valid[1] ? mem_q[1][rd_ptr_q[1]] : '0;

endmodule

// File: tb/tb_demux_buffered.sv
// Testbench for demux_buffered: directed scenarios plus a random soak, all
// compared against a two-queue reference model of the routing rules.
module tb_demux_buffered;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int SW    = 1 + 2 * (1 + CW + WIDTH);

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic [CW-1:0]    out0_count;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic [CW-1:0]    out1_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one queue of words per output.
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];

  demux_buffered #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out0_count (out0_count),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out1_count (out1_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Protocol: destination must be known whenever a word is offered.
  always @(posedge clk) begin
    if (rst_n && in_valid) begin
      assert (!$isunknown(in_sel)) else $error("protocol: in_sel unknown with in_valid");
    end
  end

  function automatic logic [SW-1:0] obs_status();
    return {in_ready, out0_valid, out0_count, out0_data, out1_valid, out1_count, out1_data};
  endfunction

  function automatic logic [SW-1:0] exp_status();
    logic             rdy;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    rdy = rst_n && ((in_sel ? q1.size() : q0.size()) < DEPTH);
    d0  = (q0.size() > 0) ? q0[0] : '0;
    d1  = (q1.size() > 0) ? q1[0] : '0;
    return {rdy, q0.size() > 0, CW'(q0.size()), d0, q1.size() > 0, CW'(q1.size()), d1};
  endfunction

  // Advance one clock and apply the model's view of that edge.
  task automatic tick();
    bit               acc;
    bit               p0;
    bit               p1;
    logic             s;
    logic [WIDTH-1:0] d;
    acc = rst_n && in_valid && ((in_sel ? q1.size() : q0.size()) < DEPTH);
    p0  = rst_n && (q0.size() > 0) && out0_ready;
    p1  = rst_n && (q1.size() > 0) && out1_ready;
    s   = in_sel;
    d   = in_data;
    @(posedge clk);
    if (!rst_n) begin
      q0.delete();
      q1.delete();
    end else begin
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      if (acc) begin
        if (s) q1.push_back(d);
        else   q0.push_back(d);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_sel     = 1'b0;
    in_data    = '0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    repeat (3) tick();
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_in_ready_low: got %b exp 0", in_ready);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (obs_status() !== {1'b1, {(SW-1){1'b0}}}) begin
      n_errors++;
      $display("FAIL reset_idle: got %h exp %h", obs_status(), {1'b1, {(SW-1){1'b0}}});
    end
    tick();
  endtask

  task automatic test_single_route();
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    in_valid   = 1'b1;
    in_sel     = 1'b0;
    in_data    = 32'hDEADBEEF;
    #1;
    n_checks++;
    if (obs_status() !== exp_status()) begin
      n_errors++;
      $display("FAIL route_pre: got %h exp %h", obs_status(), exp_status());
    end
    tick();
    in_sel  = 1'b1;
    in_data = 32'h12345678;
    #1;
    n_checks++;
    if (!(out0_valid === 1'b1 && out0_data === 32'hDEADBEEF && out1_valid === 1'b0)) begin
      n_errors++;
      $display("FAIL route_out0: got v=%b d=%h v1=%b exp v=1 d=deadbeef v1=0",
               out0_valid, out0_data, out1_valid);
    end
    tick();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (!(out0_valid === 1'b0 && out1_valid === 1'b1 && out1_data === 32'h12345678)) begin
      n_errors++;
      $display("FAIL route_out1: got v0=%b v1=%b d1=%h exp v0=0 v1=1 d1=12345678",
               out0_valid, out1_valid, out1_data);
    end
    tick();
    #1;
    n_checks++;
    if (obs_status() !== exp_status() || out1_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL route_drained: got %h exp %h", obs_status(), exp_status());
    end
    tick();
  endtask

  task automatic test_fill_backpressure();
    out0_ready = 1'b0;
    out1_ready = 1'b1;
    in_valid   = 1'b1;
    in_sel     = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_data = 32'hA0 + i;
      tick();
    end
    in_data = 32'hA2;
    #1;
    n_checks++;
    if (!(in_ready === 1'b0 && out0_count === CW'(2) && out0_data === 32'hA0)) begin
      n_errors++;
      $display("FAIL fill_full: got rdy=%b cnt=%0d d=%h exp rdy=0 cnt=2 d=a0",
               in_ready, out0_count, out0_data);
    end
    tick();
    in_valid = 1'b0;
    in_sel   = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL fill_other_sel: got rdy=%b exp 1", in_ready);
    end
    in_valid   = 1'b1;
    in_sel     = 1'b0;
    out0_ready = 1'b1;
    #1;
    n_checks++;
    if (!(in_ready === 1'b0 && out0_data === 32'hA0)) begin
      n_errors++;
      $display("FAIL fill_no_bypass: got rdy=%b d=%h exp rdy=0 d=a0", in_ready, out0_data);
    end
    tick();
    #1;
    n_checks++;
    if (!(in_ready === 1'b1 && out0_count === CW'(1) && out0_data === 32'hA1)) begin
      n_errors++;
      $display("FAIL fill_after_pop: got rdy=%b cnt=%0d d=%h exp rdy=1 cnt=1 d=a1",
               in_ready, out0_count, out0_data);
    end
    tick();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (!(out0_count === CW'(1) && out0_data === 32'hA2)) begin
      n_errors++;
      $display("FAIL fill_a2: got cnt=%0d d=%h exp cnt=1 d=a2", out0_count, out0_data);
    end
    tick();
    #1;
    n_checks++;
    if (obs_status() !== exp_status() || out0_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL fill_drained: got %h exp %h", obs_status(), exp_status());
    end
  endtask

  task automatic test_push_pop_wrap();
    out1_ready = 1'b0;
    in_valid   = 1'b1;
    in_sel     = 1'b1;
    in_data    = 32'h100;
    tick();
    out1_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 32'h101 + i;
      #1;
      n_checks++;
      if (!(out1_count === CW'(1) && out1_data === (32'h100 + i) && in_ready === 1'b1)) begin
        n_errors++;
        $display("FAIL pushpop[%0d]: got cnt=%0d d=%h rdy=%b exp cnt=1 d=%h rdy=1",
                 i, out1_count, out1_data, in_ready, 32'h100 + i);
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (!(out1_data === 32'h10A && obs_status() === exp_status())) begin
      n_errors++;
      $display("FAIL pushpop_tail: got %h exp %h", obs_status(), exp_status());
    end
    tick();
  endtask

  task automatic test_async_reset();
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    in_valid   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_sel  = i[0];
      in_data = 32'hC0DE_0000 + i;
      tick();
    end
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (!(out0_count === CW'(2) && out1_count === CW'(2))) begin
      n_errors++;
      $display("FAIL areset_prefill: got c0=%0d c1=%0d exp 2 2", out0_count, out1_count);
    end
    #1;
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    n_checks++;
    if ({in_ready, out0_valid, out1_valid, out0_count, out1_count, out0_data, out1_data} !== '0) begin
      n_errors++;
      $display("FAIL areset_immediate: got rdy=%b v=%b%b c=%0d/%0d d=%h/%h exp all 0",
               in_ready, out0_valid, out1_valid, out0_count, out1_count, out0_data, out1_data);
    end
    tick();
    tick();
    rst_n      = 1'b1;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (obs_status() !== exp_status() || out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL areset_release[%0d]: got %h exp %h", i, obs_status(), exp_status());
      end
      tick();
    end
  endtask

  task automatic test_random_soak();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_sel     = $urandom_range(0, 1) != 0;
      in_data    = $urandom;
      out0_ready = ($urandom_range(0, 2) != 0);
      out1_ready = ($urandom_range(0, 3) == 0);
      #1;
      n_checks++;
      if (obs_status() !== exp_status()) begin
        n_errors++;
        $display("FAIL soak[%0d]: got %h exp %h", cyc, obs_status(), exp_status());
      end
      n_checks++;
      if (out0_count > CW'(DEPTH) || out1_count > CW'(DEPTH) ||
          (in_ready && ((in_sel ? out1_count : out0_count) == CW'(DEPTH)))) begin
        n_errors++;
        $display("FAIL soak_bounds[%0d]: got c0=%0d c1=%0d rdy=%b sel=%b exp c<=%0d, no ready when full",
                 cyc, out0_count, out1_count, in_ready, in_sel, DEPTH);
      end
      tick();
    end
    in_valid   = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    repeat (DEPTH + 1) tick();
    #1;
    n_checks++;
    if (obs_status() !== exp_status() || out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL soak_drain: got %h exp %h", obs_status(), exp_status());
    end
  endtask

  initial begin
    test_reset();
    test_single_route();
    test_fill_backpressure();
    test_push_pop_wrap();
    test_async_reset();
    test_random_soak();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
